fp_mult_pipe: RTL and testbench
===============================

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (legal range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width (legal range 4..52).
REQ-003 SHALL have localparam W = 1+EXP_W+MAN_W (operand/result width) and BIAS = 2^(EXP_W-1)-1.
REQ-004 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: in_valid  input  1  operands a/b are valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port: a, b  input  W  IEEE-style operands {sign, exp, man}.
REQ-009 SHALL have port: out_valid  output  1  res and per-result flags are valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port: res  output  W  product.
REQ-012 SHALL have port: exception, overflow, underflow  output  1 each  per-result flags, qualified by out_valid.
REQ-013 SHALL have port: flag_clr  input  1  clears the sticky flags.
REQ-014 SHALL have port: sticky_flags  output  3  {exception, overflow, underflow}, OR-accumulated over delivered results.

Function
REQ-015 SHALL have a fixed 3-stage pipeline: S1 unpack + mantissa multiply; S2 normalise + round; S3 classify + pack, registered outputs.
REQ-016 SHALL use advance = !out_valid | out_ready; when advance is 0, all stages hold; in_ready = advance.
REQ-017 SHALL accept a transfer when in_valid & in_ready; its result reaches out_valid exactly 3 cycles later when no stall occurs.
REQ-018 SHALL track a per-stage valid bit; bubbles propagate as invalid, and data in invalid stages is don't-care.
REQ-019 SHALL sustain throughput of one result per cycle while out_ready = 1.
REQ-020 SHALL compute sign = a.sign XOR b.sign.
REQ-021 SHALL use hidden bit = 1 if the exponent field is non-zero, else 0.
REQ-022 SHALL form product P of width 2*(MAN_W+1) as the unsigned product of the two (MAN_W+1)-bit significands.
REQ-023 SHALL set nrm = P[MSB]; if nrm = 0, P SHALL be left-shifted by 1.
REQ-024 SHALL take mantissa from the next MAN_W bits below MSB, with guard bit below those and sticky = OR of all remaining lower bits.
REQ-025 SHALL round by adding 1 to the mantissa iff guard & (sticky | mantissa LSB), i.e. round to nearest, ties to even.
REQ-026 SHALL handle rounding carry-out of the mantissa by setting the mantissa to 0 and incrementing the exponent.
REQ-027 SHALL compute exponent e = ea + eb - BIAS + nrm + carry as a signed (EXP_W+2)-bit value.
REQ-028 SHALL apply the following priority: exception, zero, overflow, underflow, normal.
REQ-029 SHALL set exception = 1 when either exponent field is all ones; res = 0.
REQ-030 SHALL set zero when P = 0 (exception = 0): res = {sign, 0}; overflow = underflow = 0.
REQ-031 SHALL set overflow = 1 when e >= 2^EXP_W - 1: res = {sign, all-ones exp, 0 mantissa}.
REQ-032 SHALL set underflow = 1 when e <= 0: res = {sign, 0}; no subnormal output is produced.
REQ-033 SHALL otherwise output res = {sign, e[EXP_W-1:0], mantissa} with all flags 0.
REQ-034 SHALL update sticky_flags only on the out_valid & out_ready handshake, by OR-ing in the per-result flags.
REQ-035 SHALL clear sticky_flags when flag_clr = 1; if flag_clr coincides with a delivery, the clear wins and that delivery's flags are dropped.

Reset
REQ-036 SHALL on reset clear all stage valid bits, out_valid, res, the per-result flags and sticky_flags to 0; in_ready reads 1 in the first cycle after reset.
REQ-037 SHALL discard any in-flight operations on reset asserted mid-operation; no result from them appears afterwards.
REQ-038 SHALL take reset priority over in_valid and flag_clr in the same cycle.

Verification
REQ-039 SHALL pass (defaults) a=0x3FC00000, b=0x40000000, out_ready=1 -> res=0x40400000 three cycles later, flags 0.
REQ-040 SHALL pass a=0x3F800000, b=0x3F800000 -> res=0x3F800000, not classified as zero; a=0x00000000, b=0x40000000 -> res=0x00000000.
REQ-041 SHALL pass a=0x7F000000, b=0x7F000000 -> res=0x7F800000, overflow=1; a=0x00800000, b=0x00800000 -> res=0x00000000, underflow=1; sticky_flags=3'b011 after both deliveries.
REQ-042 SHALL pass a=0x7F800000, b=0x3F800000 -> res=0x00000000, exception=1; then flag_clr pulse -> sticky_flags=0.
REQ-043 SHALL pass a stream of 6 back-to-back operands with out_ready held low for 4 cycles mid-stream -> in_ready=0 while out_valid & !out_ready, no loss or duplication, and results in order.
REQ-044 SHALL pass a reset pulse with 2 operations in flight -> out_valid stays 0 until a new operand is accepted, whose result then arrives after 3 cycles.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier: unpack/multiply, normalise/round, classify/pack.
// Valid/ready handshake with whole-pipe stall and sticky exception/overflow/underflow flags.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         exception,
  output logic         overflow,
  output logic         underflow,
  input  logic         flag_clr,
  output logic [2:0]   sticky_flags
);

  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX   = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EZERO  = '0;

  // Returns {carry, mantissa}; round to nearest, ties to even.
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] man,
                                               input logic guard, input logic sticky);
    logic rnd;
    rnd = guard & (sticky | man[0]);
    return {1'b0, man} + (MAN_W + 1)'(rnd);
  endfunction

  // Returns {exception, overflow, underflow, res} in priority order.
  function automatic logic [W+2:0] pack_result(input logic sign, input logic exc,
                                               input logic zero,
                                               input logic signed [EW-1:0] e,
                                               input logic [MAN_W-1:0] man);
    logic [W+2:0] r;
    r = '0;
    if (exc) begin
      r[W+2] = 1'b1;
    end else if (zero) begin
      r[W-1] = sign;
    end else if (e >= EMAX) begin
      r[W+1]   = 1'b1;
      r[W-1:0] = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e <= EZERO) begin
      r[W]   = 1'b1;
      r[W-1] = sign;
    end else begin
      r[W-1:0] = {sign, e[EXP_W-1:0], man};
    end
    return r;
  endfunction

  logic                 adv;
  logic [SW-1:0]        sig_a, sig_b;
  logic                 nrm;
  logic [PW-1:0]        prod_n;
  logic [MAN_W:0]       rnd_res;
  logic [W+2:0]         pk;

  logic                 vld_p1_d, vld_p1_q, sign_p1_d, sign_p1_q, exc_p1_d, exc_p1_q;
  logic signed [EW-1:0] e_p1_d, e_p1_q;
  logic [PW-1:0]        prod_p1_d, prod_p1_q;

  logic                 vld_p2_d, vld_p2_q, sign_p2_d, sign_p2_q, exc_p2_d, exc_p2_q;
  logic                 zero_p2_d, zero_p2_q;
  logic signed [EW-1:0] e_p2_d, e_p2_q;
  logic [MAN_W-1:0]     man_p2_d, man_p2_q;

  logic                 out_valid_d, out_valid_q;
  logic [W-1:0]         res_d, res_q;
  logic                 exc_d, exc_q, ovf_d, ovf_q, unf_d, unf_q;
  logic [2:0]           sticky_d, sticky_q;

  assign sig_a = {|a[W-2:MAN_W], a[MAN_W-1:0]};
  assign sig_b = {|b[W-2:MAN_W], b[MAN_W-1:0]};

  always_comb begin
    adv = !out_valid_q || out_ready;

    // S1: unpack + mantissa multiply
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    exc_p1_d  = exc_p1_q;
    e_p1_d    = e_p1_q;
    prod_p1_d = prod_p1_q;
    if (adv) begin
      vld_p1_d  = in_valid;
      sign_p1_d = a[W-1] ^ b[W-1];
      exc_p1_d  = (&a[W-2:MAN_W]) | (&b[W-2:MAN_W]);
      e_p1_d    = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS_E;
      prod_p1_d = PW'(sig_a) * PW'(sig_b);
    end

    // S2: normalise + round
    nrm     = prod_p1_q[PW-1];
    prod_n  = nrm ? prod_p1_q : {prod_p1_q[PW-2:0], 1'b0};
    rnd_res = round_rne(prod_n[PW-2 -: MAN_W], prod_n[PW-2-MAN_W], |prod_n[PW-3-MAN_W:0]);
    vld_p2_d  = vld_p2_q;
    sign_p2_d = sign_p2_q;
    exc_p2_d  = exc_p2_q;
    zero_p2_d = zero_p2_q;
    e_p2_d    = e_p2_q;
    man_p2_d  = man_p2_q;
    if (adv) begin
      vld_p2_d  = vld_p1_q;
      sign_p2_d = sign_p1_q;
      exc_p2_d  = exc_p1_q;
      zero_p2_d = (prod_p1_q == '0);
      e_p2_d    = e_p1_q + $signed(EW'(nrm)) + $signed(EW'(rnd_res[MAN_W]));
      man_p2_d  = rnd_res[MAN_W-1:0];
    end

    // S3: classify + pack into the output registers
    pk          = pack_result(sign_p2_q, exc_p2_q, zero_p2_q, e_p2_q, man_p2_q);
    out_valid_d = out_valid_q;
    res_d       = res_q;
    exc_d       = exc_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (adv) begin
      out_valid_d = vld_p2_q;
      {exc_d, ovf_d, unf_d, res_d} = pk;
    end

    sticky_d = sticky_q;
    if (flag_clr) begin
      sticky_d = '0;
    end else if (out_valid_q && out_ready) begin
      sticky_d = sticky_q | {exc_q, ovf_q, unf_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      sticky_q    <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      exc_q       <= exc_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      sticky_q    <= sticky_d;
    end
  end

  // Datapath payload is only meaningful under its stage valid, so it is not reset.
  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    exc_p1_q  <= exc_p1_d;
    e_p1_q    <= e_p1_d;
    prod_p1_q <= prod_p1_d;
    sign_p2_q <= sign_p2_d;
    exc_p2_q  <= exc_p2_d;
    zero_p2_q <= zero_p2_d;
    e_p2_q    <= e_p2_d;
    man_p2_q  <= man_p2_d;
  end

  assign in_ready     = adv;
  assign out_valid    = out_valid_q;
  assign res          = res_q;
  assign exception    = exc_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe (binary32 defaults) with hand-computed expected results.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic        exception, overflow, underflow, flag_clr;
  logic [31:0] a, b, res;
  logic [2:0]  sticky_flags;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .exception(exception), .overflow(overflow), .underflow(underflow),
    .flag_clr(flag_clr), .sticky_flags(sticky_flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair; returns 1ns after the edge on which its result becomes visible.
  task automatic send_one(input logic [31:0] av, input logic [31:0] bv);
    in_valid = 1'b1; a = av; b = bv; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; flag_clr = 1'b1; out_ready = 1'b1;
    a = 32'h3FC00000; b = 32'h40000000;
    step();
    step();
    reset = 1'b0; in_valid = 1'b0; flag_clr = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL reset_res got=%h want=00000000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {exception, overflow, underflow}); end
    checks++; if (sticky_flags !== 3'b000) begin failures++; $display("FAIL reset_sticky got=%b want=000", sticky_flags); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_priority_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1 got=%b want=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat2 got=%b want=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_lat3 got=%b want=1", out_valid); end
    checks++; if (res !== 32'h40400000) begin failures++; $display("FAIL basic_res got=%h want=40400000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b want=000", {exception, overflow, underflow}); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_single got=%b want=0", out_valid); end
  endtask

  task automatic test_one_zero();
    send_one(32'h3F800000, 32'h3F800000);
    checks++; if (res !== 32'h3F800000) begin failures++; $display("FAIL one_res got=%h want=3F800000", res); end
    send_one(32'h00000000, 32'h40000000);
    checks++; if (res !== 32'h00000000) begin failures++; $display("FAIL zero_res got=%h want=00000000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL zero_flags got=%b want=000", {exception, overflow, underflow}); end
    step();
  endtask

  task automatic test_rounding();
    send_one(32'h3F800001, 32'h3FC00000);
    checks++; if (res !== 32'h3FC00002) begin failures++; $display("FAIL round_tie_odd got=%h want=3FC00002", res); end
    send_one(32'h3F800003, 32'h3FC00000);
    checks++; if (res !== 32'h3FC00004) begin failures++; $display("FAIL round_tie_even got=%h want=3FC00004", res); end
    send_one(32'h3F800001, 32'h3F800001);
    checks++; if (res !== 32'h3F800002) begin failures++; $display("FAIL round_below_half got=%h want=3F800002", res); end
    step();
  endtask

  task automatic test_ovf_unf();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    send_one(32'h7F000000, 32'h7F000000);
    checks++; if (res !== 32'h7F800000) begin failures++; $display("FAIL ovf_res got=%h want=7F800000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b010) begin failures++; $display("FAIL ovf_flags got=%b want=010", {exception, overflow, underflow}); end
    send_one(32'h00800000, 32'h00800000);
    checks++; if (res !== 32'h00000000) begin failures++; $display("FAIL unf_res got=%h want=00000000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b001) begin failures++; $display("FAIL unf_flags got=%b want=001", {exception, overflow, underflow}); end
    step();
    checks++; if (sticky_flags !== 3'b011) begin failures++; $display("FAIL ovf_unf_sticky got=%b want=011", sticky_flags); end
  endtask

  task automatic test_exception();
    send_one(32'h7F800000, 32'h3F800000);
    checks++; if (res !== 32'h00000000) begin failures++; $display("FAIL exc_res got=%h want=00000000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b100) begin failures++; $display("FAIL exc_flags got=%b want=100", {exception, overflow, underflow}); end
    step();
    checks++; if (sticky_flags !== 3'b111) begin failures++; $display("FAIL exc_sticky got=%b want=111", sticky_flags); end
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 3'b000) begin failures++; $display("FAIL flag_clr got=%b want=000", sticky_flags); end
    send_one(32'h3F800000, 32'hFF800000);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 3'b000) begin failures++; $display("FAIL clr_vs_delivery got=%b want=000", sticky_flags); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [6];
    logic [31:0] vexp [6];
    int idx, ridx;
    logic acc;
    va   = '{32'h3F800000, 32'h3FC00000, 32'h3FA00000, 32'h3FE00000, 32'h40400000, 32'h3F000000};
    vexp = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h40600000, 32'h40C00000, 32'h3F800000};
    idx = 0; ridx = 0;
    step(); step(); step();
    for (int cyc = 0; cyc < 40 && ridx < 6; cyc++) begin
      in_valid  = (idx < 6);
      a         = (idx < 6) ? va[idx] : 32'h0;
      b         = 32'h40000000;
      out_ready = !(cyc >= 4 && cyc < 8);
      #1;
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++; if (res !== vexp[ridx]) begin failures++; $display("FAIL b2b_res idx=%0d got=%h want=%h", ridx, res, vexp[ridx]); end
        ridx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (ridx != 6) begin failures++; $display("FAIL b2b_count got=%0d want=6", ridx); end
    checks++; if (idx != 6) begin failures++; $display("FAIL b2b_accepted got=%0d want=6", idx); end
    step(); step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    step();
    a = 32'h3F800000;
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_flushed got=%b want=0", seen); end
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_lat1 got=%b want=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_lat2 got=%b want=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midreset_lat3 got=%b want=1", out_valid); end
    checks++; if (res !== 32'h40400000) begin failures++; $display("FAIL midreset_res got=%h want=40400000", res); end
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    a = '0; b = '0;
    step();
    test_reset();
    test_basic();
    test_one_zero();
    test_rounding();
    test_ovf_unf();
    test_exception();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
